// File: rtl/mult_div_pkg.sv
// Shared types and constants for the multiply/divide issue scheduler.
// Optional feature macro: MULT_DIV_FASTPATH_EN (divide/remainder by zero resolved without the unit).
package mult_div_pkg;

  localparam int MD_ROB_DEPTH = 4;
  localparam int MD_TAG_W     = $clog2(MD_ROB_DEPTH);
  localparam int XLEN         = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    BCAST
  } sched_state_t;

  localparam logic [2:0] MUL_F3    = 3'b000;
  localparam logic [2:0] MULH_F3   = 3'b001;
  localparam logic [2:0] MULHSU_F3 = 3'b010;
  localparam logic [2:0] MULHU_F3  = 3'b011;
  localparam logic [2:0] DIV_F3    = 3'b100;
  localparam logic [2:0] DIVU_F3   = 3'b101;
  localparam logic [2:0] REM_F3    = 3'b110;
  localparam logic [2:0] REMU_F3   = 3'b111;

  typedef struct packed {
    logic [2:0]          funct3;
    logic [XLEN-1:0]     rs1;
    logic [XLEN-1:0]     rs2;
    logic [MD_TAG_W-1:0] tag;
  } md_op_t;

  // Architectural result of a divide/remainder by zero: quotient is all ones,
  // remainder is the dividend.
  function automatic logic [XLEN-1:0] div_by_zero_result(input md_op_t op);
    if (op.funct3 == REM_F3 || op.funct3 == REMU_F3) return op.rs1;
    return '1;
  endfunction

endpackage

// File: rtl/md_op_fifo.sv
// In-order pending-op queue: circular buffer with a count register and a
// synchronous clear that takes priority over push and pop.
module md_op_fifo
  import mult_div_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   clear,
  input  logic   push,
  input  md_op_t push_op,
  input  logic   pop,
  output md_op_t head_op,
  output logic   full,
  output logic   empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  md_op_t           mem [DEPTH];

  logic do_push;
  logic do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head_op = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state uses non-blocking assignments so every flop samples the pre-edge values.
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage has no reset; the count guards every read, so stale entries are never observed.
    if (do_push && !clear) mem[wr_ptr] <= push_op;
  end

endmodule

// File: rtl/mult_div_sched.sv
// Issue scheduler and result sequencer for the shared multi-cycle mul/div unit.
// Queues ops in order, issues one at a time with a start pulse, holds operands,
// captures the result and presents it to the CDB with a valid/ready handshake.
// Optional feature macro: MULT_DIV_FASTPATH_EN resolves DIV/DIVU/REM/REMU by
// zero in IDLE without starting the unit.
module mult_div_sched
  import mult_div_pkg::*;
#(
  parameter int ROB_DEPTH   = MD_ROB_DEPTH,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [2:0]                   req_funct3,
  input  logic [31:0]                  req_rs1_v,
  input  logic [31:0]                  req_rs2_v,
  input  logic [$clog2(ROB_DEPTH)-1:0] req_rob_tag,
  output logic                         unit_start,
  output logic [2:0]                   unit_funct3,
  output logic [31:0]                  unit_rs1_v,
  output logic [31:0]                  unit_rs2_v,
  output logic                         unit_flush,
  input  logic                         unit_done,
  input  logic [31:0]                  unit_result,
  output logic                         cdb_valid,
  input  logic                         cdb_ready,
  output logic [31:0]                  cdb_result,
  output logic [$clog2(ROB_DEPTH)-1:0] cdb_rob,
  output logic                         busy
);

  sched_state_t state_q;
  sched_state_t state_d;

  md_op_t      req_op;
  md_op_t      head_op;
  md_op_t      iss_op;
  logic [31:0] res_value;
  logic [$clog2(ROB_DEPTH)-1:0] res_tag;

  logic q_full;
  logic q_empty;
  logic q_push;
  logic q_pop;
  logic fast_hit;

  assign req_op = '{funct3: req_funct3, rs1: req_rs1_v, rs2: req_rs2_v, tag: req_rob_tag};

  // No same-cycle bypass: a full queue refuses even while it is being popped.
  assign req_ready = !q_full;
  assign q_push    = req_valid && req_ready && !flush;

`ifdef MULT_DIV_FASTPATH_EN
  assign fast_hit = head_op.funct3[2] && (head_op.rs2 == '0);
`else
  assign fast_hit = 1'b0;
`endif

  md_op_fifo #(
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (flush),
    .push    (q_push),
    .push_op (req_op),
    .pop     (q_pop),
    .head_op (head_op),
    .full    (q_full),
    .empty   (q_empty)
  );

  // Next-state and pop decision; flush overrides every other event.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a signal unassigned (no latch).
    state_d = state_q;
    q_pop   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!q_empty) begin
          q_pop   = 1'b1;
          state_d = fast_hit ? BCAST : ISSUE;
        end
      end
      ISSUE:   state_d = WAIT;
      WAIT:    if (unit_done) state_d = BCAST;
      BCAST:   if (cdb_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      q_pop   = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Issue registers: loaded on every pop and held until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     iss_op <= '0;
    else if (q_pop) iss_op <= head_op;
  end

  // Result registers: captured from the unit in WAIT, or directly from the
  // head op on a fast-path pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_value <= '0;
      res_tag   <= '0;
    end else if (!flush) begin
      if (state_q == WAIT && unit_done) begin
        res_value <= unit_result;
        res_tag   <= iss_op.tag;
      end else if (q_pop && fast_hit) begin
        res_value <= div_by_zero_result(head_op);
        res_tag   <= head_op.tag;
      end
    end
  end

  assign unit_start  = (state_q == ISSUE) && !flush;
  assign unit_flush  = flush && (state_q == ISSUE || state_q == WAIT);
  assign unit_funct3 = iss_op.funct3;
  assign unit_rs1_v  = iss_op.rs1;
  assign unit_rs2_v  = iss_op.rs2;

  // A broadcast in the flush cycle still stands; it drops on the next cycle.
  assign cdb_valid  = (state_q == BCAST);
  assign cdb_result = res_value;
  assign cdb_rob    = res_tag;

  assign busy = !q_empty || (state_q != IDLE);

endmodule

// File: tb/tb_mult_div_sched.sv
// Scoreboard bench for mult_div_sched: stimulus pushes expected issues and
// CDB transfers into queues; a monitor pops and compares on each event.
module tb_mult_div_sched;
  import mult_div_pkg::*;

  localparam int TW = MD_TAG_W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [2:0]    req_funct3 = '0;
  logic [31:0]   req_rs1_v = '0;
  logic [31:0]   req_rs2_v = '0;
  logic [TW-1:0] req_rob_tag = '0;
  logic          unit_start;
  logic [2:0]    unit_funct3;
  logic [31:0]   unit_rs1_v;
  logic [31:0]   unit_rs2_v;
  logic          unit_flush;
  logic          unit_done = 1'b0;
  logic [31:0]   unit_result = '0;
  logic          cdb_valid;
  logic          cdb_ready = 1'b0;
  logic [31:0]   cdb_result;
  logic [TW-1:0] cdb_rob;
  logic          busy;

  mult_div_sched #(
    .ROB_DEPTH   (MD_ROB_DEPTH),
    .QUEUE_DEPTH (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_funct3  (req_funct3),
    .req_rs1_v   (req_rs1_v),
    .req_rs2_v   (req_rs2_v),
    .req_rob_tag (req_rob_tag),
    .unit_start  (unit_start),
    .unit_funct3 (unit_funct3),
    .unit_rs1_v  (unit_rs1_v),
    .unit_rs2_v  (unit_rs2_v),
    .unit_flush  (unit_flush),
    .unit_done   (unit_done),
    .unit_result (unit_result),
    .cdb_valid   (cdb_valid),
    .cdb_ready   (cdb_ready),
    .cdb_result  (cdb_result),
    .cdb_rob     (cdb_rob),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  f3;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } iss_t;

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [31:0]   res;
  } cdb_t;

  iss_t exp_iss[$];
  cdb_t exp_cdb[$];
  iss_t mon_iss;
  cdb_t mon_cdb;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares every unit start and every CDB transfer with the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (unit_start) begin
        check("start_expected", exp_iss.size() != 0, 1'b1);
        if (exp_iss.size() != 0) begin
          mon_iss = exp_iss.pop_front();
          check("issue_operands", {unit_funct3, unit_rs1_v, unit_rs2_v}, mon_iss);
        end
      end
      if (cdb_valid && cdb_ready) begin
        check("cdb_expected", exp_cdb.size() != 0, 1'b1);
        if (exp_cdb.size() != 0) begin
          mon_cdb = exp_cdb.pop_front();
          check("cdb_transfer", {cdb_rob, cdb_result}, mon_cdb);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_op(input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [TW-1:0] tag, input bit expect_issue);
    req_funct3  = f3;
    req_rs1_v   = rs1;
    req_rs2_v   = rs2;
    req_rob_tag = tag;
    req_valid   = 1'b1;
    for (int i = 0; i < 50 && !req_ready; i++) tick();
    check("push_ready", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
    if (expect_issue) exp_iss.push_back('{f3: f3, rs1: rs1, rs2: rs2});
  endtask

  task automatic wait_start(input string name);
    for (int i = 0; i < 40 && !unit_start; i++) tick();
    check(name, unit_start, 1'b1);
  endtask

  task automatic wait_cdb(input string name);
    for (int i = 0; i < 40 && !cdb_valid; i++) tick();
    check(name, cdb_valid, 1'b1);
  endtask

  task automatic accept_cdb();
    cdb_ready = 1'b1;
    tick();
    cdb_ready = 1'b0;
  endtask

  // Run one op already queued or issuing through the unit and the CDB.
  task automatic serve(input logic [31:0] result, input logic [TW-1:0] tag);
    wait_start("serve_start");
    repeat (3) tick();
    unit_done   = 1'b1;
    unit_result = result;
    exp_cdb.push_back('{tag: tag, res: result});
    tick();
    unit_done = 1'b0;
    wait_cdb("serve_cdb");
    accept_cdb();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    // Reset state.
    #12;
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_outputs", {unit_start, unit_flush, cdb_valid, busy}, 4'b0000);
    check("rst_regs", {unit_funct3, unit_rs1_v, unit_rs2_v, cdb_result, cdb_rob}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single MUL: start two cycles after the push, result one cycle after done.
    push_op(MUL_F3, 32'd7, 32'd6, TW'(2), 1'b1);
    check("mul_no_early_start", unit_start, 1'b0);
    tick();
    check("mul_start_latency", unit_start, 1'b1);
    repeat (8) tick();
    unit_done   = 1'b1;
    unit_result = 32'd42;
    exp_cdb.push_back('{tag: TW'(2), res: 32'd42});
    tick();
    unit_done = 1'b0;
    check("mul_cdb", {cdb_valid, cdb_rob, cdb_result}, {1'b1, TW'(2), 32'd42});
    unit_done   = 1'b1;
    unit_result = 32'd99;
    tick();
    unit_done = 1'b0;
    check("done_ignored_in_bcast", {cdb_valid, cdb_result}, {1'b1, 32'd42});
    accept_cdb();
    check("mul_idle", {cdb_valid, busy}, 2'b00);

    // Queue full behind an in-flight op; a fifth request is refused.
    push_op(MULH_F3, 32'h1000, 32'h2000, TW'(3), 1'b1);
    wait_start("full_first_start");
    push_op(MULHSU_F3, 32'd11, 32'd12, TW'(0), 1'b1);
    push_op(MULHU_F3,  32'd21, 32'd22, TW'(1), 1'b1);
    push_op(DIV_F3,    32'd31, 32'd32, TW'(2), 1'b1);
    push_op(REMU_F3,   32'd41, 32'd42, TW'(3), 1'b1);
    check("full_ready_low", req_ready, 1'b0);
    req_funct3  = MUL_F3;
    req_rs1_v   = 32'hBAD;
    req_rs2_v   = 32'hBAD;
    req_rob_tag = TW'(1);
    req_valid   = 1'b1;
    tick();
    req_valid = 1'b0;
    check("full_still_low", req_ready, 1'b0);
    unit_done   = 1'b1;
    unit_result = 32'h0200_0000;
    exp_cdb.push_back('{tag: TW'(3), res: 32'h0200_0000});
    tick();
    unit_done = 1'b0;
    wait_cdb("full_first_cdb");
    accept_cdb();
    tick();
    check("accept_to_start", unit_start, 1'b1);
    serve(32'd132, TW'(0));
    serve(32'd462, TW'(1));
    serve(32'd0,   TW'(2));
    serve(32'd41,  TW'(3));
    check("full_drained", busy, 1'b0);

    // CDB backpressure: outputs hold for five cycles, one transfer only.
    push_op(MULHU_F3, 32'hFFFF_FFFF, 32'd2, TW'(1), 1'b1);
    wait_start("bp_start");
    repeat (2) tick();
    unit_done   = 1'b1;
    unit_result = 32'hDEAD_BEEF;
    exp_cdb.push_back('{tag: TW'(1), res: 32'hDEAD_BEEF});
    tick();
    unit_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_stable", {cdb_valid, cdb_rob, cdb_result}, {1'b1, TW'(1), 32'hDEAD_BEEF});
      tick();
    end
    accept_cdb();
    check("bp_single_transfer", cdb_valid, 1'b0);

    // Flush in WAIT with two ops queued.
    push_op(MUL_F3, 32'd3, 32'd4, TW'(0), 1'b1);
    wait_start("flush_wait_start");
    push_op(DIV_F3, 32'd100, 32'd7, TW'(1), 1'b1);
    push_op(REM_F3, 32'd100, 32'd7, TW'(2), 1'b1);
    flush = 1'b1;
    exp_iss.delete();
    #1;
    check("flush_wait_pulse", unit_flush, 1'b1);
    tick();
    flush = 1'b0;
    check("flush_wait_after", {unit_flush, busy}, 2'b00);
    unit_done   = 1'b1;
    unit_result = 32'd12;
    tick();
    unit_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("late_done_ignored", {cdb_valid, unit_start}, 2'b00);
      tick();
    end

    // Flush in the same cycle as a request while idle and empty.
    req_funct3  = MUL_F3;
    req_rs1_v   = 32'd5;
    req_rs2_v   = 32'd5;
    req_rob_tag = TW'(3);
    req_valid   = 1'b1;
    flush       = 1'b1;
    #1;
    check("flush_idle_no_pulse", unit_flush, 1'b0);
    tick();
    req_valid = 1'b0;
    flush     = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("flush_req_dropped", {busy, unit_start}, 2'b00);
      tick();
    end

    // Divide/remainder by zero.
`ifdef MULT_DIV_FASTPATH_EN
    push_op(DIVU_F3, 32'd5, 32'd0, TW'(3), 1'b0);
    exp_cdb.push_back('{tag: TW'(3), res: 32'hFFFF_FFFF});
    tick();
    check("fast_divu", {cdb_valid, cdb_rob, cdb_result}, {1'b1, TW'(3), 32'hFFFF_FFFF});
    accept_cdb();
    push_op(REM_F3, 32'd5, 32'd0, TW'(0), 1'b0);
    exp_cdb.push_back('{tag: TW'(0), res: 32'd5});
    tick();
    check("fast_rem", {cdb_valid, cdb_rob, cdb_result}, {1'b1, TW'(0), 32'd5});
    accept_cdb();
`else
    push_op(DIVU_F3, 32'd5, 32'd0, TW'(3), 1'b1);
    push_op(REM_F3,  32'd5, 32'd0, TW'(0), 1'b1);
    serve(32'hFFFF_FFFF, TW'(3));
    serve(32'd5,         TW'(0));
`endif
    check("dz_idle", busy, 1'b0);

    // Flush during BCAST with cdb_ready: that broadcast stands.
    push_op(MUL_F3, 32'd9, 32'd9, TW'(1), 1'b1);
    wait_start("flush_bcast_start");
    repeat (2) tick();
    unit_done   = 1'b1;
    unit_result = 32'd81;
    exp_cdb.push_back('{tag: TW'(1), res: 32'd81});
    tick();
    unit_done = 1'b0;
    check("flush_bcast_valid", cdb_valid, 1'b1);
    flush     = 1'b1;
    cdb_ready = 1'b1;
    tick();
    flush     = 1'b0;
    cdb_ready = 1'b0;
    check("flush_bcast_after", {cdb_valid, busy}, 2'b00);

    // Asynchronous reset mid-operation: everything stops, no abort pulse.
    push_op(MUL_F3, 32'd2, 32'd3, TW'(0), 1'b1);
    wait_start("arst_start");
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_abort", {unit_flush, unit_start, cdb_valid, busy, req_ready}, 5'b00001);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("arst_idle", busy, 1'b0);

    check("iss_queue_drained", exp_iss.size(), 0);
    check("cdb_queue_drained", exp_cdb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
